des_round_key_gen: RTL and testbench

- Sequential DES key schedule. Sits directly upstream of the Feistel f-function stage and supplies its 48-bit round key input.
- Accepts a 64-bit key and a direction flag. Emits 16 round keys, one per valid/ready handshake: K1..K16 for encryption, K16..K1 for decryption.
- Applies PC-1 once at load, rotates the C/D halves per round, and applies PC-2 to produce each output.

---
 rtl/des_round_key_gen.sv | 160 ++++++++++++++++
 tb/tb_des_round_key_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_key_gen.sv
// rtl/des_round_key_gen.sv - sequential DES key schedule: PC-1 at load, C/D rotation per round, PC-2 output
// Optional: define DES_KEY_PARITY_CHECK_EN to add the parity_err output (odd-parity check of key_in bytes).
module des_round_key_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [0:63] key_in,
    input  logic        decrypt,
    input  logic        key_ready,
    output logic        key_valid,
    output logic [0:47] round_key,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    output logic        parity_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [0:55] pc1(input logic [0:63] k);
        logic [0:55] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[i] = k[6'(PC1[i] - 1)];
        end
        return r;
    endfunction

    function automatic logic [0:47] pc2(input logic [0:55] cd);
        logic [0:47] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[i] = cd[6'(PC2[i] - 1)];
        end
        return r;
    endfunction

    function automatic logic [0:27] rotl(input logic [0:27] h, input logic by_two);
        return by_two ? {h[2:27], h[0:1]} : {h[1:27], h[0]};
    endfunction

    function automatic logic [0:27] rotr(input logic [0:27] h, input logic by_two);
        return by_two ? {h[26:27], h[0:25]} : {h[27], h[0:26]};
    endfunction

    state_t      state_q;
    state_t      state_d;
    logic [0:27] c_q;
    logic [0:27] d_q;
    logic        dir_q;
    logic [3:0]  idx_q;

    logic        load;
    logic        fire;
    logic        advance;
    logic        single_shift;
    logic [0:55] cd0;

    assign load    = (state_q == IDLE) && start;
    assign fire    = (state_q == RUN) && key_ready;
    assign advance = fire && (idx_q != 4'd15);
    assign cd0     = pc1(key_in);

    // Encrypt uses s(i+2), decrypt uses s(16-i); both are 1 exactly at positions 0, 7 and 14.
    assign single_shift = (idx_q == 4'd0) || (idx_q == 4'd7) || (idx_q == 4'd14);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (key_ready && (idx_q == 4'd15)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            dir_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                dir_q <= decrypt;
                idx_q <= '0;
                // Decrypt starts from C16/D16, which equals C0/D0 after a full 28-bit rotation.
                if (decrypt) begin
                    c_q <= cd0[0:27];
                    d_q <= cd0[28:55];
                end else begin
                    c_q <= rotl(cd0[0:27], 1'b0);
                    d_q <= rotl(cd0[28:55], 1'b0);
                end
            end else if (advance) begin
                idx_q <= idx_q + 4'd1;
                if (dir_q) begin
                    c_q <= rotr(c_q, !single_shift);
                    d_q <= rotr(d_q, !single_shift);
                end else begin
                    c_q <= rotl(c_q, !single_shift);
                    d_q <= rotl(d_q, !single_shift);
                end
            end
        end
    end

    assign round_key = pc2({c_q, d_q});
    assign round_idx = idx_q;
    assign key_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

`ifdef DES_KEY_PARITY_CHECK_EN
    function automatic logic even_byte_found(input logic [0:63] k);
        logic err;
        err = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (^k[8*b +: 8] == 1'b0) err = 1'b1;
        end
        return err;
    endfunction

    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= even_byte_found(key_in);
        end
    end

    assign parity_err = parity_q;
`endif

endmodule

// File: tb/tb_des_round_key_gen.sv
// tb/tb_des_round_key_gen.sv - scoreboard testbench for des_round_key_gen
`timescale 1ns/1ps
module tb_des_round_key_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [0:63] key_in = '0;
    logic        decrypt = 1'b0;
    logic        key_ready = 1'b0;
    logic        key_valid;
    logic [0:47] round_key;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;
`ifdef DES_KEY_PARITY_CHECK_EN
    logic        parity_err;
`endif

    always #5 clk = ~clk;

    des_round_key_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .decrypt   (decrypt),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
`ifdef DES_KEY_PARITY_CHECK_EN
        ,
        .parity_err(parity_err)
`endif
    );

    typedef struct packed {
        logic [3:0]  idx;
        logic [47:0] key;
    } exp_t;

    localparam logic [63:0] KEY     = 64'h133457799BBCDFF1;
    localparam logic [63:0] ALT_KEY = 64'hFEDCBA9876543210;
    localparam logic [63:0] PAR_KEY = 64'h0101010101010101;

    localparam logic [47:0] KEY_TAB [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   t_start  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted key is popped from the scoreboard and compared.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n && key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_key: got idx %0d key 0x%h expected none", round_idx, round_key);
            end else begin
                e = exp_q.pop_front();
                check("key_idx", 64'(round_idx), 64'(e.idx));
                check("round_key", 64'(round_key), 64'(e.key));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 = encrypt order, 1 = decrypt order, 2 = all-zero keys
    task automatic issue_start(input logic [63:0] k, input logic dec, input int mode);
        start   = 1'b1;
        key_in  = k;
        decrypt = dec;
        t_start = cyc;
        for (int n = 0; n < 16; n++) begin
            exp_t e;
            e.idx = 4'(n);
            if (mode == 2)      e.key = '0;
            else if (mode == 1) e.key = KEY_TAB[15-n];
            else                e.key = KEY_TAB[n];
            exp_q.push_back(e);
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_idx(input logic [3:0] n);
        int k;
        for (k = 0; k < 200; k++) begin
            if (busy && round_idx == n) break;
            step();
        end
        if (k == 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idx_timeout: got idx %0d expected %0d", round_idx, n);
        end
    endtask

    task automatic wait_done(input logic check_lat);
        int k;
        for (k = 0; k < 200; k++) begin
            if (done) break;
            step();
        end
        if (k == 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done_timeout: got done=%0d expected 1", done);
        end else if (check_lat) begin
            check("done_latency", 64'(cyc - t_start), 64'd17);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        step();
        step();
        check("reset_key_valid", 64'(key_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_round_idx", 64'(round_idx), 64'd0);
        check("reset_round_key", 64'(round_key), 64'd0);
`ifdef DES_KEY_PARITY_CHECK_EN
        check("reset_parity_err", 64'(parity_err), 64'd0);
`endif
        rst_n     = 1'b1;
        key_ready = 1'b1;
        step();

        // Encrypt, full throughput
        issue_start(KEY, 1'b0, 0);
        check("busy_after_start", 64'(busy), 64'd1);
`ifdef DES_KEY_PARITY_CHECK_EN
        check("parity_err_good_key", 64'(parity_err), 64'd0);
`endif
        wait_done(1'b1);
        step();
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("queue_drained_enc", 64'(exp_q.size()), 64'd0);

        // Decrypt, full throughput
        issue_start(KEY, 1'b1, 1);
        wait_done(1'b1);
        step();
        check("queue_drained_dec", 64'(exp_q.size()), 64'd0);

        // Backpressure at round_idx 3
        issue_start(KEY, 1'b0, 0);
        wait_idx(4'd3);
        key_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 64'(key_valid), 64'd1);
            check("stall_idx", 64'(round_idx), 64'd3);
            check("stall_key", 64'(round_key), 64'(KEY_TAB[3]));
        end
        @(posedge clk);
        #1;
        key_ready = 1'b1;
        wait_done(1'b0);
        step();
        check("queue_drained_stall", 64'(exp_q.size()), 64'd0);

        // start during RUN is ignored; start in DONE ignored, one cycle later accepted
        issue_start(KEY, 1'b0, 0);
        wait_idx(4'd7);
        start   = 1'b1;
        key_in  = ALT_KEY;
        decrypt = 1'b1;
        step();
        start = 1'b0;
        wait_done(1'b1);
        start   = 1'b1;
        key_in  = ALT_KEY;
        decrypt = 1'b1;
        step();
        start = 1'b0;
        check("done_start_ignored_busy", 64'(busy), 64'd0);
        check("done_start_ignored_valid", 64'(key_valid), 64'd0);
        issue_start(KEY, 1'b0, 0);
        check("start_after_done_busy", 64'(busy), 64'd1);
        wait_done(1'b1);
        step();
        check("queue_drained_restart", 64'(exp_q.size()), 64'd0);

        // Reset mid-run at round_idx 9
        issue_start(KEY, 1'b0, 0);
        wait_idx(4'd9);
        rst_n = 1'b0;
        #1;
        check("midreset_key_valid", 64'(key_valid), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_round_idx", 64'(round_idx), 64'd0);
        check("midreset_round_key", 64'(round_key), 64'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        issue_start(KEY, 1'b0, 0);
        wait_done(1'b1);
        step();
        check("queue_drained_after_reset", 64'(exp_q.size()), 64'd0);

        // Parity-bits-only key: PC-1 discards every set bit
        issue_start(PAR_KEY, 1'b0, 2);
`ifdef DES_KEY_PARITY_CHECK_EN
        check("parity_err_0101_key", 64'(parity_err), 64'd0);
`endif
        wait_done(1'b1);
        step();
        check("queue_drained_zero", 64'(exp_q.size()), 64'd0);

`ifdef DES_KEY_PARITY_CHECK_EN
        // Last byte 0xF0 has even parity; key schedule is unaffected by parity bits
        issue_start(64'h133457799BBCDFF0, 1'b0, 0);
        check("parity_err_even_byte", 64'(parity_err), 64'd1);
        wait_done(1'b1);
        step();
        check("parity_err_holds", 64'(parity_err), 64'd1);
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
